switch_allocator: RTL and testbench
===================================

// Module: switch_allocator
// PURPOSE
// - Router-level switch allocator; shares the 5 crossbar outputs among the 5 input ports (inport_*) of one router node.
// - Each inport raises sa_request with a one-hot outport. Per output, round-robin arbitration picks one winner.
// - Wormhole locking: a granted head flit holds the output until that input's tail flit is granted.
// - Also drives crossbar select lines. Sits between the inports and the crossbar, one instance per router.
// PARAMETERS
// - NUM_PORTS  5  number of inputs/outputs; fixed encoding bit0 N, bit1 E, bit2 S, bit3 W, bit4 LOCAL
// - LOCK_EN    1  1 = wormhole lock head..tail; 0 = arbitrate every flit independently
// PORTS
// - clk                    in   1    single clock, all state updates on posedge
// - rst                    in   1    synchronous, active-high reset
// - sa_request             in   5    bit i: input i requests switch this cycle
// - req_outport            in   25   [5i+4:5i] one-hot output requested by input i
// - req_tail               in   5    bit i: flit at head of input i is a tail (single-flit packet = tail)
// - valid_downstream_ports in   5    bit o: output o may accept a flit this cycle
// - sa_grant               out  5    bit i: input i granted this cycle (one-hot onto PORT_DIR of winner)
// - xbar_sel               out  25   [5o+4:5o] one-hot input driving output o; 0 = idle
// - out_locked             out  5    bit o: output o held by an in-flight packet
// - err_outport            out  1    sticky: a request with non-one-hot req_outport was seen
// BEHAVIOUR
// - State: ptr[o] (3b, 0..4) round-robin pointer; lock_valid[o]; lock_owner[o] (3b); err_outport.
// - Reset (rst=1 at posedge): ptr=0, lock_valid=0, lock_owner=0, err_outport=0.
//   While rst=1, sa_grant=0 and xbar_sel=0, forced combinationally. out_locked=0 after reset.
// - Grants are combinational from current inputs plus registered state (0-cycle latency).
//   The inport sees sa_grant in the same cycle it requests. State updates at the next posedge.
// - Eligible(i,o): sa_request[i] & req_outport[i]==onehot(o) & valid_downstream_ports[o].
// - Non-one-hot req_outport (zero or >1 bits) with sa_request: never eligible; err_outport sets at next posedge and stays until rst.
// - Output o locked: only lock_owner[o] may win o; other eligible inputs are stalled, with no grant and no ptr change.
// - Output o unlocked: winner = first eligible i scanning ptr[o], ptr[o]+1, ... mod 5.
// - On a grant of input i on output o (registered at posedge):
//   - ptr[o] <= (i+1) mod 5, only when o was unlocked; a locked grant leaves ptr unchanged.
//   - LOCK_EN=1 & !req_tail[i]: lock_valid[o]<=1, lock_owner[o]<=i.
//   - req_tail[i]: lock_valid[o]<=0 (single-flit packet never locks).
// - valid_downstream_ports[o]=0 while locked: no grant; lock is held, not released.
// - An input requests at most one output, so sa_grant is at most one bit per input. Each xbar_sel slice is at most one-hot.
// - sa_grant[i] = OR over o of xbar_sel[5o+i].
// - Lock owner drops sa_request mid-packet: lock is held (wormhole); the output stays reserved.
// - Different outputs arbitrate independently; up to 5 grants in one cycle.
// - out_locked = lock_valid (registered).
// - LOCK_EN=0: lock_valid stays 0; ptr advances on every grant.
// TESTING
// - Reset: rst=1 with all sa_request=1 -> sa_grant=0, xbar_sel=0. After release, ptr=0: inputs 0,2 request E (00010) -> grant 00001, xbar_sel[9:5]=00001.
// - Round-robin: inputs 0,1,2 hold tail requests to S for 3 cycles -> grants 0,1,2 in order. 4th cycle grants 0 again (ptr wraps 3->...->0).
// - Wormhole lock: input 3 head (tail=0) to LOCAL, then input 1 also requests LOCAL.
//   -> input 1 stalled while out_locked[4]=1. Input 3 tail granted -> unlock; input 1 granted next cycle.
// - Backpressure: locked output N with valid_downstream_ports[0]=0 for 4 cycles -> no grant, lock held.
//   Restore -> owner granted first cycle.
// - Parallel / error: inputs 0..4 to distinct outputs -> sa_grant=11111 same cycle.
//   Input 2 req_outport=00110 -> no grant for 2, err_outport=1 next cycle, stays until rst.
// - Reset mid-packet: rst pulse while out_locked=00100 -> out_locked=0, ptr=0. A new request from any input arbitrates normally.

Source files
------------

// File: rtl/switch_allocator_if.sv
// Switch-allocation bus between the router inports and the switch allocator.
// master = inport side (issues requests), slave = allocator (returns grants / crossbar selects).
interface switch_allocator_if #(
  parameter int unsigned NUM_PORTS = 5
);
  logic [NUM_PORTS-1:0]           sa_request;
  logic [NUM_PORTS*NUM_PORTS-1:0] req_outport;
  logic [NUM_PORTS-1:0]           req_tail;
  logic [NUM_PORTS-1:0]           valid_downstream_ports;
  logic [NUM_PORTS-1:0]           sa_grant;
  logic [NUM_PORTS*NUM_PORTS-1:0] xbar_sel;
  logic [NUM_PORTS-1:0]           out_locked;
  logic                           err_outport;

  modport master (
    output sa_request, req_outport, req_tail, valid_downstream_ports,
    input  sa_grant, xbar_sel, out_locked, err_outport
  );

  modport slave (
    input  sa_request, req_outport, req_tail, valid_downstream_ports,
    output sa_grant, xbar_sel, out_locked, err_outport
  );
endinterface

// File: rtl/switch_allocator.sv
// Router switch allocator: per-output round-robin arbitration with optional wormhole
// locking from head to tail flit; grants and crossbar selects are same-cycle.
module switch_allocator #(
  parameter int unsigned NUM_PORTS = 5,
  parameter bit          LOCK_EN   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave sa
);
  localparam int unsigned PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned PW1 = PW + 1;

  typedef logic [NUM_PORTS-1:0] vec_t;

  vec_t [NUM_PORTS-1:0]          req_oh;   // [input] requested output
  vec_t [NUM_PORTS-1:0]          elig;     // [output] eligible inputs
  vec_t [NUM_PORTS-1:0]          sel;      // [output] one-hot winning input
  logic [NUM_PORTS-1:0][PW-1:0]  ptr;
  logic [NUM_PORTS-1:0][PW-1:0]  lock_owner;
  logic [NUM_PORTS-1:0][PW-1:0]  win_idx;
  vec_t                          lock_valid;
  vec_t                          req_ok;
  vec_t                          req_bad;
  vec_t                          grant;
  logic                          err_q;

  assign req_oh = sa.req_outport;

  // First set bit of cand, scanning upward from start with wrap-around.
  function automatic vec_t rr_pick(input vec_t cand, input logic [PW-1:0] start);
    logic           found;
    logic [PW1-1:0] pos;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      pos = PW1'(start) + PW1'(k);
      if (pos >= PW1'(NUM_PORTS)) pos = pos - PW1'(NUM_PORTS);
      if (!found && cand[pos[PW-1:0]]) begin
        rr_pick[pos[PW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  endfunction

  function automatic logic [PW-1:0] oh_index(input vec_t oh);
    oh_index = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (oh[k]) oh_index = PW'(k);
    end
  endfunction

  // Malformed requests (zero or multiple outports) never compete.
  always_comb begin
    req_ok  = '0;
    req_bad = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_ok[i]  = sa.sa_request[i] &  $onehot(req_oh[i]);
      req_bad[i] = sa.sa_request[i] & ~$onehot(req_oh[i]);
    end
  end

  // Per-output arbitration; a locked output only serves its owner.
  always_comb begin
    elig    = '0;
    sel     = '0;
    win_idx = '0;
    grant   = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        elig[o][i] = req_ok[i] & req_oh[i][o] & sa.valid_downstream_ports[o];
      end
      if (lock_valid[o]) begin
        if (elig[o][lock_owner[o]]) sel[o][lock_owner[o]] = 1'b1;
      end else begin
        sel[o] = rr_pick(elig[o], ptr[o]);
      end
      if (rst) sel[o] = '0;
      win_idx[o] = oh_index(sel[o]);
      grant      = grant | sel[o];
    end
  end

  assign sa.sa_grant    = grant;
  assign sa.xbar_sel    = sel;
  assign sa.out_locked  = lock_valid;
  assign sa.err_outport = err_q;

  // Pointer advances only on unlocked grants; tail flits release the lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      lock_valid <= '0;
      lock_owner <= '0;
      err_q      <= 1'b0;
    end else begin
      if (|req_bad) err_q <= 1'b1;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (|sel[o]) begin
          if (!lock_valid[o]) begin
            ptr[o] <= (win_idx[o] == PW'(NUM_PORTS - 1)) ? '0 : win_idx[o] + PW'(1);
          end
          if (sa.req_tail[win_idx[o]]) begin
            lock_valid[o] <= 1'b0;
          end else if (LOCK_EN) begin
            lock_valid[o] <= 1'b1;
            lock_owner[o] <= win_idx[o];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios followed by random
// traffic, all compared against a behavioural per-output model.
module tb_switch_allocator;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] req, tail, vdp;
  logic [N-1:0] outp [N];

  switch_allocator_if #(.NUM_PORTS(N)) bus ();

  assign bus.sa_request             = req;
  assign bus.req_tail               = tail;
  assign bus.valid_downstream_ports = vdp;
  assign bus.req_outport            = {outp[4], outp[3], outp[2], outp[1], outp[0]};

  switch_allocator #(.NUM_PORTS(N), .LOCK_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .sa  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: round-robin start per output, lock owner per output (-1 = free), sticky error.
  int ptr_m   [N];
  int owner_m [N];
  int win_m   [N];
  bit err_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit eligible(input int i, input int o);
    return req[i] && $onehot(outp[i]) && outp[i][o] && vdp[o];
  endfunction

  // Winner per output: locked -> owner only; free -> eligible input closest after ptr.
  function automatic void model_comb(output logic [N-1:0] g, output logic [N*N-1:0] xs);
    int bd;
    int d;
    g  = '0;
    xs = '0;
    for (int o = 0; o < N; o++) begin
      win_m[o] = -1;
      if (!rst) begin
        if (owner_m[o] >= 0) begin
          if (eligible(owner_m[o], o)) win_m[o] = owner_m[o];
        end else begin
          bd = N;
          for (int i = 0; i < N; i++) begin
            d = (i - ptr_m[o] + N) % N;
            if (eligible(i, o) && d < bd) begin
              bd       = d;
              win_m[o] = i;
            end
          end
        end
        if (win_m[o] >= 0) begin
          g[win_m[o]]       = 1'b1;
          xs[N*o + win_m[o]] = 1'b1;
        end
      end
    end
  endfunction

  function automatic void model_update();
    if (rst) begin
      err_m = 1'b0;
      for (int o = 0; o < N; o++) begin
        ptr_m[o]   = 0;
        owner_m[o] = -1;
      end
    end else begin
      for (int i = 0; i < N; i++)
        if (req[i] && !$onehot(outp[i])) err_m = 1'b1;
      for (int o = 0; o < N; o++) begin
        if (win_m[o] >= 0) begin
          if (owner_m[o] < 0) ptr_m[o] = (win_m[o] + 1) % N;
          owner_m[o] = tail[win_m[o]] ? -1 : win_m[o];
        end
      end
    end
  endfunction

  function automatic logic [N-1:0] locked_m();
    logic [N-1:0] l;
    l = '0;
    for (int o = 0; o < N; o++) l[o] = (owner_m[o] >= 0);
    return l;
  endfunction

  // One cycle: inputs already driven; compare outputs, then clock and advance the model.
  task automatic step(input string tag, input int exp_g);
    logic [N-1:0]   eg;
    logic [N*N-1:0] ex;
    #1;
    model_comb(eg, ex);
    chk({tag, "/grant"},  32'(bus.sa_grant),    32'(eg));
    chk({tag, "/xbar"},   32'(bus.xbar_sel),    32'(ex));
    chk({tag, "/locked"}, 32'(bus.out_locked),  32'(locked_m()));
    chk({tag, "/err"},    32'(bus.err_outport), 32'(err_m));
    if (exp_g >= 0) chk({tag, "/grant_ref"}, 32'(bus.sa_grant), 32'(exp_g));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    req  = '0;
    tail = '0;
    vdp  = '1;
    for (int i = 0; i < N; i++) outp[i] = '0;
  endtask

  initial begin
    int rr_exp [4] = '{1, 2, 4, 1};

    // Reset with every input requesting
    rst  = 1'b1;
    req  = '1;
    tail = '1;
    vdp  = '1;
    for (int i = 0; i < N; i++) outp[i] = 5'(1 << i);
    @(posedge clk);
    model_update();
    #1;
    step("reset", 0);

    // First arbitration after reset: ptr=0 favours input 0 on E
    rst = 1'b0;
    idle();
    tail    = '1;
    req[0]  = 1'b1;
    req[2]  = 1'b1;
    outp[0] = 5'b00010;
    outp[2] = 5'b00010;
    #1;
    chk("init_xsel_e", 32'(bus.xbar_sel[9:5]), 32'd1);
    step("init_e", 5'b00001);

    // Round-robin on S with three tail requesters
    idle();
    tail = '1;
    req  = 5'b00111;
    for (int i = 0; i < 3; i++) outp[i] = 5'b00100;
    for (int k = 0; k < 4; k++) step("rr", rr_exp[k]);

    // Wormhole lock on LOCAL
    idle();
    req[3]  = 1'b1;
    outp[3] = 5'b10000;
    step("wh_head", 5'b01000);
    chk("wh_locked", 32'(bus.out_locked), 32'h10);
    req[1]  = 1'b1;
    outp[1] = 5'b10000;
    tail[1] = 1'b1;
    step("wh_stall", 5'b01000);
    req[3] = 1'b0;
    step("wh_owner_drop", 5'b00000);
    chk("wh_held", 32'(bus.out_locked), 32'h10);
    req[3]  = 1'b1;
    tail[3] = 1'b1;
    step("wh_tail", 5'b01000);
    chk("wh_unlock", 32'(bus.out_locked), 32'h00);
    req[3] = 1'b0;
    step("wh_next", 5'b00010);

    // Backpressure on a locked N output
    idle();
    req[0]  = 1'b1;
    outp[0] = 5'b00001;
    step("bp_head", 5'b00001);
    req[4]  = 1'b1;
    outp[4] = 5'b00001;
    tail[4] = 1'b1;
    vdp[0]  = 1'b0;
    repeat (4) begin
      step("bp_stall", 5'b00000);
      chk("bp_held", 32'(bus.out_locked), 32'h01);
    end
    vdp     = '1;
    tail[0] = 1'b1;
    step("bp_restore", 5'b00001);
    chk("bp_unlock", 32'(bus.out_locked), 32'h00);

    // All five inputs to distinct outputs in one cycle
    idle();
    tail = '1;
    req  = '1;
    for (int i = 0; i < N; i++) outp[i] = 5'(1 << ((i + 1) % N));
    step("parallel", 5'b11111);

    // Malformed outport on input 2
    outp[2] = 5'b00110;
    step("err_req", 5'b11011);
    chk("err_set", 32'(bus.err_outport), 32'd1);
    idle();
    step("err_hold", 5'b00000);
    chk("err_sticky", 32'(bus.err_outport), 32'd1);

    // Reset while S is locked
    req[1]  = 1'b1;
    outp[1] = 5'b00100;
    step("rm_head", 5'b00010);
    chk("rm_locked", 32'(bus.out_locked), 32'h04);
    rst = 1'b1;
    idle();
    step("rm_rst", 5'b00000);
    rst = 1'b0;
    chk("rm_unlocked", 32'(bus.out_locked), 32'h00);
    chk("rm_err_clr", 32'(bus.err_outport), 32'd0);
    req[3]  = 1'b1;
    outp[3] = 5'b00100;
    tail[3] = 1'b1;
    step("rm_new", 5'b01000);

    // Random traffic against the model
    repeat (400) begin
      rst = ($urandom_range(63) == 0);
      for (int i = 0; i < N; i++) begin
        req[i]  = 1'($urandom_range(1));
        tail[i] = ($urandom_range(2) == 0);
        vdp[i]  = ($urandom_range(4) != 0);
        outp[i] = ($urandom_range(19) == 0) ? 5'($urandom_range(31))
                                            : 5'(1 << $urandom_range(4));
      end
      step("rand", -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
